// File: rtl/pwm_audio_sequencer.sv
// -----------------------------------------------------------------------------
// pwm_audio_sequencer
//
// Sample-playback controller for a 5-bit PWM audio stage. Incoming samples are
// queued in a small FIFO. The module owns the free-running PWM period counter
// and changes the duty reference only at period boundaries, so the downstream
// comparator (duty > count -> high) never sees a duty change mid-period.
// Each sample is held for HOLD full periods.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   start        one-cycle request to begin playback (IDLE only)
//   stop         one-cycle request to finish after the FIFO drains
//   s_data       5-bit sample to enqueue
//   s_valid      s_data valid; push happens when s_valid && s_ready
//   s_ready      FIFO not full (0 while reset is asserted)
//   pwm_count    period counter 0..31 for the comparator
//   pwm_ref      duty reference for the comparator
//   period_start high while pwm_count == 0
//   busy         sequencer is in PLAY or DRAIN
//   underrun     one-cycle pulse when a due load in PLAY found the FIFO empty
//   fifo_level   FIFO occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module pwm_audio_sequencer #(
    parameter int DEPTH      = 8,
    parameter int HOLD       = 4,
    parameter int IDLE_LEVEL = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stop,
    input  logic [4:0]                   s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [4:0]                   pwm_count,
    output logic [4:0]                   pwm_ref,
    output logic                         period_start,
    output logic                         busy,
    output logic                         underrun,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_q;
    logic [4:0]      cnt_q;
    logic [7:0]      hcnt_q;
    logic [4:0]      ref_q;
    logic            underrun_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic [LW-1:0]   level_d;
    logic [4:0]      mem [DEPTH];

    logic            boundary;
    logic            fifo_empty;
    logic            fifo_full;
    logic            load_due;
    logic            push;
    logic            pop;
    logic [4:0]      head;

    assign boundary   = (cnt_q == 5'd31);
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LW'(DEPTH));
    // s_ready follows only the full flag; it is forced low while reset is held.
    assign s_ready    = reset && !fifo_full;
    assign push       = s_valid && s_ready;
    assign load_due   = boundary && (hcnt_q == 8'd0) && (state_q != ST_IDLE);
    // Emptiness is judged on the registered level, so a push in the same
    // cycle as a load is never visible to that load.
    assign pop        = load_due && !fifo_empty;
    assign head       = mem[rd_ptr_q];

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    // Sample storage has no reset: stale entries are unreachable once the
    // pointers and level are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 5'd0;
            hcnt_q     <= 8'd0;
            ref_q      <= 5'(IDLE_LEVEL);
            underrun_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            cnt_q      <= cnt_q + 5'd1;
            underrun_q <= 1'b0;
            level_q    <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    ref_q <= 5'(IDLE_LEVEL);
                    // stop has priority over a simultaneous start.
                    if (start && !stop) begin
                        state_q <= ST_PLAY;
                        hcnt_q  <= 8'd0;
                    end
                end
                ST_PLAY, ST_DRAIN: begin
                    if (boundary) begin
                        if (hcnt_q != 8'd0) begin
                            hcnt_q <= hcnt_q - 8'd1;
                        end else if (!fifo_empty) begin
                            ref_q  <= head;
                            hcnt_q <= 8'(HOLD - 1);
                        end else begin
                            // Nothing to play: go silent and retry next period.
                            ref_q <= 5'(IDLE_LEVEL);
                            if (state_q == ST_DRAIN) begin
                                state_q <= ST_IDLE;
                            end else begin
                                underrun_q <= 1'b1;
                            end
                        end
                    end
                    if (state_q == ST_PLAY && stop) begin
                        state_q <= ST_DRAIN;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pwm_count    = cnt_q;
    assign pwm_ref      = ref_q;
    assign period_start = (cnt_q == 5'd0);
    assign busy         = (state_q != ST_IDLE);
    assign underrun     = underrun_q;
    assign fifo_level   = level_q;

endmodule

// File: tb/tb_pwm_audio_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pwm_audio_sequencer
//
// Directed bench for pwm_audio_sequencer (DEPTH=8, HOLD=4, IDLE_LEVEL=16).
// Inputs change on the falling clock edge; outputs are sampled on the falling
// edge. A reference period counter (exp_cnt) tracks where the PWM period
// should be, and all waits are positioned against it.
// -----------------------------------------------------------------------------
module tb_pwm_audio_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic [4:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [4:0] pwm_count;
    logic [4:0] pwm_ref;
    logic       period_start;
    logic       busy;
    logic       underrun;
    logic [3:0] fifo_level;

    int errors = 0;
    int checks = 0;

    logic [4:0] exp_cnt = 5'd0;

    pwm_audio_sequencer #(.DEPTH(8), .HOLD(4), .IDLE_LEVEL(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .pwm_count    (pwm_count),
        .pwm_ref      (pwm_ref),
        .period_start (period_start),
        .busy         (busy),
        .underrun     (underrun),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    // Reference period counter.
    always @(posedge clk or negedge reset) begin
        if (!reset) exp_cnt <= 5'd0;
        else        exp_cnt <= exp_cnt + 5'd1;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_cnt(input logic [4:0] v);
        for (int i = 0; i < 33 && exp_cnt != v; i++) @(negedge clk);
    endtask

    task automatic push(input logic [4:0] v);
        s_data = v; s_valid = 1'b1;
        step(1);
        s_valid = 1'b0;
    endtask

    task automatic pulse(input logic st, input logic sp);
        start = st; stop = sp;
        step(1);
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = 5'd0;
        step(3);
        checks++; if (pwm_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", pwm_count); end
        checks++; if (pwm_ref !== 5'd16) begin errors++; $display("FAIL reset_ref got=%0d exp=16", pwm_ref); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", s_ready); end
        checks++; if (busy !== 1'b0 || underrun !== 1'b0) begin errors++; $display("FAIL reset_busy_underrun got=%b%b exp=00", busy, underrun); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL reset_period_start got=%b exp=1", period_start); end
        reset = 1'b1;
        step(1);
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_idle_count;
        for (int i = 0; i < 64; i++) begin
            checks++; if (pwm_count !== exp_cnt) begin errors++; $display("FAIL idle_count got=%0d exp=%0d", pwm_count, exp_cnt); end
            checks++; if (period_start !== (exp_cnt == 5'd0)) begin errors++; $display("FAIL idle_period_start cnt=%0d got=%b", exp_cnt, period_start); end
            step(1);
        end
        checks++; if (pwm_ref !== 5'd16 || s_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL idle_outputs ref=%0d ready=%b busy=%b exp 16/1/0", pwm_ref, s_ready, busy); end
        $display("test_idle_count done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_playback;
        logic [4:0] samp [3];
        logic       seen;
        samp[0] = 5'd3; samp[1] = 5'd7; samp[2] = 5'd31;
        for (int i = 0; i < 3; i++) push(samp[i]);
        checks++; if (fifo_level !== 4'd3) begin errors++; $display("FAIL play_level_init got=%0d exp=3", fifo_level); end
        wait_cnt(5'd5);
        pulse(1'b1, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL play_busy got=%b exp=1", busy); end
        wait_cnt(5'd31);
        checks++; if (pwm_ref !== 5'd16 || fifo_level !== 4'd3) begin errors++; $display("FAIL play_before_load ref=%0d level=%0d exp 16/3", pwm_ref, fifo_level); end
        step(1);
        for (int i = 0; i < 3; i++) begin
            checks++; if (pwm_ref !== samp[i]) begin errors++; $display("FAIL play_load%0d got=%0d exp=%0d", i, pwm_ref, samp[i]); end
            checks++; if (fifo_level !== 4'(2 - i)) begin errors++; $display("FAIL play_level%0d got=%0d exp=%0d", i, fifo_level, 2 - i); end
            step(127);
            checks++; if (pwm_ref !== samp[i]) begin errors++; $display("FAIL play_hold%0d got=%0d exp=%0d", i, pwm_ref, samp[i]); end
            step(1);
        end
        // FIFO ran dry: silence plus an underrun pulse once per period.
        checks++; if (pwm_ref !== 5'd16 || underrun !== 1'b1) begin errors++; $display("FAIL underrun1 ref=%0d underrun=%b exp 16/1", pwm_ref, underrun); end
        step(1);
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun1_width got=%b exp=0", underrun); end
        wait_cnt(5'd0);
        checks++; if (underrun !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL underrun2 underrun=%b busy=%b exp 1/1", underrun, busy); end
        step(4);
        push(5'd9);
        checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL underrun_push level got=%0d exp=1", fifo_level); end
        wait_cnt(5'd31);
        checks++; if (pwm_ref !== 5'd16) begin errors++; $display("FAIL underrun_pre_load got=%0d exp=16", pwm_ref); end
        step(1);
        checks++; if (pwm_ref !== 5'd9 || fifo_level !== 4'd0 || underrun !== 1'b0) begin errors++; $display("FAIL underrun_recover ref=%0d level=%0d underrun=%b exp 9/0/0", pwm_ref, fifo_level, underrun); end
        pulse(1'b0, 1'b1);
        seen = 1'b0;
        for (int i = 1; i < 128; i++) begin
            step(1);
            seen = seen | underrun;
        end
        checks++; if (pwm_ref !== 5'd16 || busy !== 1'b0 || seen !== 1'b0) begin errors++; $display("FAIL play_stop ref=%0d busy=%b underrun_seen=%b exp 16/0/0", pwm_ref, busy, seen); end
        $display("test_playback done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_full;
        for (int i = 1; i <= 8; i++) push(5'(i));
        checks++; if (s_ready !== 1'b0 || fifo_level !== 4'd8) begin errors++; $display("FAIL full ready=%b level=%0d exp 0/8", s_ready, fifo_level); end
        push(5'd30);
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL full_ninth level got=%0d exp=8", fifo_level); end
        wait_cnt(5'd3);
        pulse(1'b1, 1'b0);
        wait_cnt(5'd31);
        // Offer a sample in the pop cycle: full means it must be refused.
        s_data = 5'd20; s_valid = 1'b1;
        step(1);
        checks++; if (fifo_level !== 4'd7 || s_ready !== 1'b1 || pwm_ref !== 5'd1) begin errors++; $display("FAIL full_pop level=%0d ready=%b ref=%0d exp 7/1/1", fifo_level, s_ready, pwm_ref); end
        step(1);
        s_valid = 1'b0;
        checks++; if (fifo_level !== 4'd8 || s_ready !== 1'b0) begin errors++; $display("FAIL full_refill level=%0d ready=%b exp 8/0", fifo_level, s_ready); end
        $display("test_full done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reset_mid;
        step(40);
        reset = 1'b0;
        #1;
        checks++; if (pwm_ref !== 5'd16 || fifo_level !== 4'd0) begin errors++; $display("FAIL reset_mid ref=%0d level=%0d exp 16/0", pwm_ref, fifo_level); end
        checks++; if (pwm_count !== 5'd0 || busy !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL reset_mid count=%0d busy=%b ready=%b exp 0/0/0", pwm_count, busy, s_ready); end
        step(2);
        reset = 1'b1;
        step(1);
        checks++; if (pwm_count !== exp_cnt || pwm_count !== 5'd1) begin errors++; $display("FAIL reset_mid_release count=%0d exp=1", pwm_count); end
        $display("test_reset_mid done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_drain;
        logic seen;
        push(5'd5);
        push(5'd10);
        wait_cnt(5'd10);
        pulse(1'b1, 1'b0);
        wait_cnt(5'd0);
        checks++; if (pwm_ref !== 5'd5) begin errors++; $display("FAIL drain_first got=%0d exp=5", pwm_ref); end
        start = 1'b0; stop = 1'b1;
        seen = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            step(1);
            stop = 1'b0;
            seen = seen | underrun;
            if (k == 127) begin
                checks++; if (pwm_ref !== 5'd5 || busy !== 1'b1) begin errors++; $display("FAIL drain_hold1 ref=%0d busy=%b exp 5/1", pwm_ref, busy); end
            end
            if (k == 128) begin
                checks++; if (pwm_ref !== 5'd10 || busy !== 1'b1) begin errors++; $display("FAIL drain_second ref=%0d busy=%b exp 10/1", pwm_ref, busy); end
            end
            if (k == 255) begin
                checks++; if (pwm_ref !== 5'd10 || busy !== 1'b1) begin errors++; $display("FAIL drain_hold2 ref=%0d busy=%b exp 10/1", pwm_ref, busy); end
            end
        end
        checks++; if (pwm_ref !== 5'd16 || busy !== 1'b0 || seen !== 1'b0) begin errors++; $display("FAIL drain_end ref=%0d busy=%b underrun_seen=%b exp 16/0/0", pwm_ref, busy, seen); end
        $display("test_drain done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_back_to_back;
        logic seen;
        push(5'd12);
        wait_cnt(5'd2);
        pulse(1'b1, 1'b1);
        checks++; if (busy !== 1'b0 || fifo_level !== 4'd1) begin errors++; $display("FAIL idle_start_stop busy=%b level=%0d exp 0/1", busy, fifo_level); end
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL play_start_stop busy got=%b exp=1", busy); end
        wait_cnt(5'd0);
        checks++; if (pwm_ref !== 5'd12 || fifo_level !== 4'd0) begin errors++; $display("FAIL b2b_load ref=%0d level=%0d exp 12/0", pwm_ref, fifo_level); end
        seen = 1'b0;
        for (int k = 0; k < 128; k++) begin
            step(1);
            seen = seen | underrun;
        end
        checks++; if (pwm_ref !== 5'd16 || busy !== 1'b0 || seen !== 1'b0) begin errors++; $display("FAIL b2b_drain ref=%0d busy=%b underrun_seen=%b exp 16/0/0", pwm_ref, busy, seen); end
        $display("test_back_to_back done: checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        test_reset();
        test_idle_count();
        test_playback();
        test_full();
        test_reset_mid();
        test_drain();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
